// File: rtl/tone_monitor.sv
// Speaker tone monitor: measures the period of the speaker square wave in clk
// cycles, derives its frequency with a restoring divider, and counts distinct notes.
module tone_monitor #(
    parameter int unsigned FCLK        = 50_000_000,
    parameter int unsigned TIMEOUT_CYC = FCLK / 50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spkr_in,
    output logic [31:0] freq,
    output logic [31:0] period,
    output logic        freq_valid,
    output logic        tone_on,
    output logic [7:0]  note_count
);

    localparam int unsigned CW  = 32;
    localparam int unsigned BW  = 5;
    localparam logic [CW-1:0] TIMEOUT  = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] DIVIDEND = CW'(FCLK);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_DIVIDE = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_meas_q, cnt_meas_d;
    logic [CW-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [CW-1:0] freq_q, freq_d, period_q, period_d;
    logic          freq_valid_q, freq_valid_d, tone_on_q, tone_on_d;
    logic [7:0]    note_q, note_d;

    logic          rise;
    logic [CW:0]   rem_sh;
    logic          q_bit;
    logic [CW-1:0] rem_sub;
    logic [CW-1:0] abs_diff;

    // Next-state, datapath and output computation
    always_comb begin
        sync1_d      = spkr_in;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        state_d      = state_q;
        cnt_meas_d   = cnt_meas_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        bit_d        = bit_q;
        freq_d       = freq_q;
        period_d     = period_q;
        freq_valid_d = 1'b0;
        tone_on_d    = tone_on_q;
        note_d       = note_q;

        rise     = sync2_q & ~prev_q;
        rem_sh   = {rem_q, quo_q[CW-1]};
        q_bit    = (rem_sh >= {1'b0, cnt_meas_q});
        rem_sub  = rem_sh[CW-1:0] - cnt_meas_q;
        abs_diff = (quo_q >= freq_q) ? (quo_q - freq_q) : (freq_q - quo_q);

        // Period counter runs in every state and saturates at the timeout
        if (rise) begin
            cnt_d = CW'(1);
        end else if (cnt_q < TIMEOUT) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (rise) begin
                    cnt_meas_d = cnt_q;
                    quo_d      = DIVIDEND;
                    rem_d      = '0;
                    bit_d      = '0;
                    state_d    = S_DIVIDE;
                end else if (cnt_q == TIMEOUT) begin
                    tone_on_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_DIVIDE: begin
                rem_d = q_bit ? rem_sub : rem_sh[CW-1:0];
                quo_d = {quo_q[CW-2:0], q_bit};
                bit_d = bit_q + BW'(1);
                if (bit_q == BW'(CW - 1)) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                period_d     = cnt_meas_q;
                freq_d       = quo_q;
                freq_valid_d = 1'b1;
                // A jump of more than 1/16 of the old frequency counts as a new note
                if (!tone_on_q) begin
                    tone_on_d = 1'b1;
                    note_d    = note_q + 8'd1;
                end else if (abs_diff > (freq_q >> 4)) begin
                    note_d = note_q + 8'd1;
                end
                state_d = S_ARMED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cnt_meas_q   <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            bit_q        <= '0;
            freq_q       <= '0;
            period_q     <= '0;
            freq_valid_q <= 1'b0;
            tone_on_q    <= 1'b0;
            note_q       <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cnt_meas_q   <= cnt_meas_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            bit_q        <= bit_d;
            freq_q       <= freq_d;
            period_q     <= period_d;
            freq_valid_q <= freq_valid_d;
            tone_on_q    <= tone_on_d;
            note_q       <= note_d;
        end
    end

    assign freq       = freq_q;
    assign period     = period_q;
    assign freq_valid = freq_valid_q;
    assign tone_on    = tone_on_q;
    assign note_count = note_q;

endmodule

// File: tb/tb_tone_monitor.sv
// Directed bench for tone_monitor at FCLK=1 MHz, timeout 10000 cycles.
module tb_tone_monitor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spkr_in;
    logic [31:0] freq, period;
    logic        freq_valid, tone_on;
    logic [7:0]  note_count;

    int wave_per = 0;
    bit alt_mode = 1'b0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int rise_cnt = 0;
    int n_chk = 0;
    int n_pass = 0;
    int consec = 0;
    logic prev_fv = 1'b0;

    logic [31:0] cap_freq, cap_period, cap_lat;
    logic        cap_tone;
    logic [7:0]  cap_note;

    tone_monitor #(.FCLK(1_000_000), .TIMEOUT_CYC(10_000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spkr_in    (spkr_in),
        .freq       (freq),
        .period     (period),
        .freq_valid (freq_valid),
        .tone_on    (tone_on),
        .note_count (note_count)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_fv <= freq_valid;
        if (freq_valid === 1'b1 && prev_fv === 1'b1) consec <= consec + 1;
    end

    // Square-wave source: rises every per cycles, driven on the falling edge
    initial begin
        int per;
        bit ph;
        ph = 1'b0;
        spkr_in = 1'b0;
        @(negedge clk);
        forever begin
            if (alt_mode) begin
                per = ph ? 80 : 40;
                ph  = ~ph;
            end else begin
                per = wave_per;
            end
            if (per < 2) begin
                spkr_in = 1'b0;
                @(negedge clk);
            end else begin
                spkr_in = 1'b1;
                last_rise_cyc = cyc;
                rise_cnt++;
                repeat (per / 2) @(negedge clk);
                spkr_in = 1'b0;
                repeat (per - per / 2) @(negedge clk);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic wait_valid(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (freq_valid === 1'b1) begin
                cap_freq   = freq;
                cap_period = period;
                cap_tone   = tone_on;
                cap_note   = note_count;
                cap_lat    = 32'(cyc - last_rise_cyc);
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("valid_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_period(input int p, input int maxv);
        for (int i = 0; i < maxv; i++) begin
            wait_valid(3000);
            if (cap_period == 32'(p)) break;
        end
    endtask

    initial begin
        int r0;
        int win;

        // Reset values
        repeat (5) @(negedge clk);
        chk("rst_freq", freq, 32'd0);
        chk("rst_period", period, 32'd0);
        chk("rst_valid", 32'(freq_valid), 32'd0);
        chk("rst_tone", 32'(tone_on), 32'd0);
        chk("rst_notes", 32'(note_count), 32'd0);
        reset_n  = 1'b1;
        wave_per = 1000;

        // First measurement and its latency from the measured rise
        wait_valid(3000);
        chk("p1000_lat", cap_lat, 32'd36);
        chk("p1000_freq", cap_freq, 32'd1000);
        chk("p1000_period", cap_period, 32'd1000);
        chk("p1000_tone", 32'(cap_tone), 32'd1);
        chk("p1000_notes", 32'(cap_note), 32'd1);

        // Small change is the same note, large change is a new one
        wave_per = 1024;
        wait_period(1024, 4);
        chk("p1024_freq", cap_freq, 32'd976);
        chk("p1024_notes", 32'(cap_note), 32'd1);
        wave_per = 500;
        wait_period(500, 4);
        chk("p500_freq", cap_freq, 32'd2000);
        chk("p500_notes", 32'(cap_note), 32'd2);

        // Silence: tone drops, freq/period hold
        wave_per = 0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (tone_on === 1'b0) break;
        end
        chk("off_lat", 32'(cyc - last_rise_cyc), 32'd10003);
        chk("off_freq_hold", freq, 32'd2000);
        chk("off_period_hold", period, 32'd500);
        chk("off_notes", 32'(note_count), 32'd2);

        wave_per = 250;
        wait_period(250, 3);
        chk("p250_freq", cap_freq, 32'd4000);
        chk("p250_tone", 32'(cap_tone), 32'd1);
        chk("p250_notes", 32'(cap_note), 32'd3);

        // Minimum-ish period: exact result, sparse updates
        wave_per = 3;
        wait_period(3, 4);
        chk("p3_first_freq", cap_freq, 32'd333333);
        for (int i = 0; i < 4; i++) begin
            wait_valid(200);
            chk("p3_freq", cap_freq, 32'd333333);
            chk("p3_period", cap_period, 32'd3);
        end
        chk("p3_notes", 32'(cap_note), 32'd4);

        // Reset pulse while a measurement is being divided
        wave_per = 1000;
        wait_period(1000, 4);
        r0 = rise_cnt;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (rise_cnt != r0) break;
        end
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        win = 0;
        repeat (40) begin
            @(negedge clk);
            if (freq_valid === 1'b1) win++;
        end
        chk("mid_rst_no_valid", 32'(win), 32'd0);
        chk("mid_rst_freq", freq, 32'd0);
        chk("mid_rst_period", period, 32'd0);
        chk("mid_rst_tone", 32'(tone_on), 32'd0);
        chk("mid_rst_notes", 32'(note_count), 32'd0);
        wait_period(1000, 3);
        chk("post_rst_freq", cap_freq, 32'd1000);
        chk("post_rst_period", cap_period, 32'd1000);
        chk("post_rst_notes", 32'(cap_note), 32'd1);

        // note_count wrap: silence, then alternating 40/80 periods each make a new note
        wave_per = 0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (tone_on === 1'b0) break;
        end
        chk("wrap_start_notes", 32'(note_count), 32'd1);
        alt_mode = 1'b1;
        for (int i = 0; i < 254; i++) wait_valid(300);
        chk("wrap_255", 32'(cap_note), 32'd255);
        wait_valid(300);
        chk("wrap_0", 32'(cap_note), 32'd0);
        alt_mode = 1'b0;

        chk("no_consec_valid", 32'(consec), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
